// File: rtl/uart_tx_queue_pkg.sv
// Shared UART definitions: baud divider, default completion timeout and the
// transmit-queue controller state encodings.
package uart_tx_queue_pkg;

  localparam int CLOCK_DIVIDE    = 104;  // 12 MHz / 115200 baud
  localparam int TIMEOUT_DEFAULT = 4095;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SEND       = 2'd1,
    ST_WAIT_DONE  = 2'd2,
    ST_WAIT_CLEAR = 2'd3
  } tx_state_t;

endpackage

// File: rtl/sync_fifo16.sv
// 16-bit synchronous FIFO; pushes at full and pops at empty are ignored.
module sync_fifo16 #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic [15:0] push_data,
  input  logic        pop,
  output logic [15:0] head,
  output logic        full,
  output logic        empty,
  output logic [4:0]  count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          wr_en, rd_en;

  assign wr_en = push && !full;
  assign rd_en = pop && !empty;

  // DEPTH is a power of two, so pointer overflow wraps modulo DEPTH
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == 5'(DEPTH));
  assign empty = (count == 5'd0);

endmodule

// File: rtl/uart_tx_queue.sv
// Word queue in front of a byte UART: hands one 16-bit word per SEND strobe and
// waits for the UART's done handshake (or a timeout) before the next.
module uart_tx_queue
  import uart_tx_queue_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic [15:0] push_data,
  output logic        full,
  output logic        empty,
  output logic [4:0]  count,
  output logic        busy,
  output logic        overflow,
  output logic        timeout_err,
  output logic        uart_in_and_send,
  output logic [15:0] uart_data,
  output logic        data_oe,
  input  logic        uart_done
);

  localparam logic [11:0] TO_LAST = 12'(TIMEOUT - 1);

  tx_state_t   state_q, state_d;
  logic [11:0] wait_cnt;
  logic [15:0] last_word, head;
  logic        send, timeout_hit;

  sync_fifo16 #(.DEPTH(DEPTH)) fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (send),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // Counter reaches TIMEOUT on the same edge that abandons the word
  assign timeout_hit = (state_q == ST_WAIT_DONE) && !uart_done && (wait_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:       if (count != 5'd0 && !uart_done) state_d = ST_SEND;
      ST_SEND:       state_d = ST_WAIT_DONE;
      ST_WAIT_DONE:  if (uart_done) state_d = ST_WAIT_CLEAR;
                     else if (timeout_hit) state_d = ST_IDLE;
      ST_WAIT_CLEAR: if (!uart_done) state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    send             = (state_q == ST_SEND);
    uart_in_and_send = send;
    data_oe          = send;
    uart_data        = send ? head : last_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt    <= '0;
      last_word   <= '0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      wait_cnt <= (state_q == ST_WAIT_DONE) ? wait_cnt + 12'd1 : 12'd0;
      if (send)         last_word   <= head;
      if (push && full) overflow    <= 1'b1;
      if (timeout_hit)  timeout_err <= 1'b1;
    end
  end

  assign busy = (state_q != ST_IDLE) || (count != 5'd0);

endmodule

// File: tb/tb_uart_tx_queue.sv
// Scoreboarded bench for uart_tx_queue with a simple UART done-handshake model.
module tb_uart_tx_queue;

  localparam int DEPTH = 8;
  localparam int TO    = 40;

  logic        clk = 1'b0, reset = 1'b1, push = 1'b0;
  logic [15:0] push_data = '0;
  logic        full, empty, busy, overflow, timeout_err, uart_in_and_send, data_oe;
  logic [4:0]  count;
  logic [15:0] uart_data;
  logic        model_done = 1'b0, hold_done = 1'b0;
  logic        uart_done;
  bit          uart_dead = 1'b0;
  int          uart_lat = 3, uart_hold = 2;
  int          checks = 0, passes = 0, sends = 0, cyc = 0, send_cyc = 0;
  logic [15:0] exp_q[$];

  assign uart_done = model_done | hold_done;

  uart_tx_queue #(.DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .push(push), .push_data(push_data),
    .full(full), .empty(empty), .count(count), .busy(busy),
    .overflow(overflow), .timeout_err(timeout_err),
    .uart_in_and_send(uart_in_and_send), .uart_data(uart_data),
    .data_oe(data_oe), .uart_done(uart_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // UART model: after a SEND, raise done for uart_hold cycles after uart_lat cycles
  initial forever begin
    @(negedge clk);
    if (uart_in_and_send === 1'b1 && !uart_dead) begin
      repeat (uart_lat) @(negedge clk);
      model_done = 1'b1;
      repeat (uart_hold) @(negedge clk);
      model_done = 1'b0;
    end
  end

  // Scoreboard: every SEND pops the oldest expected word
  initial begin : monitor
    logic        prev;
    logic [15:0] e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (uart_in_and_send === 1'b1) begin
        sends++;
        send_cyc = cyc;
        checks++;
        if (exp_q.size() == 0) $display("FAIL send_unexpected got %h want no send", uart_data);
        else begin
          e = exp_q.pop_front();
          if (uart_data !== e) $display("FAIL send_order got %h want %h", uart_data, e);
          else passes++;
        end
        checks++;
        if (data_oe !== 1'b1 || uart_done !== 1'b0 || prev)
          $display("FAIL send_strobe got oe=%b done=%b prev=%b want 1 0 0", data_oe, uart_done, prev);
        else passes++;
      end
      prev = uart_in_and_send;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  task automatic do_push(input logic [15:0] w, input bit expect_send);
    @(negedge clk);
    push = 1'b1;
    push_data = w;
    if (expect_send) exp_q.push_back(w);
  endtask

  task automatic do_reset();
    @(negedge clk);
    push = 1'b0; hold_done = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < limit) begin
      @(negedge clk);
      n++;
    end
    ok = (n < limit);
  endtask

  task automatic test_reset();
    push = 1'b1; push_data = 16'h1234;
    @(negedge clk);
    checks++; if (count !== 5'd0) $display("FAIL rst_count got %0d want 0", count); else passes++;
    checks++; if ({empty, full, busy} !== 3'b100) $display("FAIL rst_flags got e/f/b=%b want 100", {empty, full, busy}); else passes++;
    checks++; if ({overflow, timeout_err} !== 2'b00) $display("FAIL rst_sticky got %b want 00", {overflow, timeout_err}); else passes++;
    checks++; if ({uart_in_and_send, data_oe} !== 2'b00) $display("FAIL rst_strobe got %b want 00", {uart_in_and_send, data_oe}); else passes++;
    checks++; if (uart_data !== 16'h0) $display("FAIL rst_data got %h want 0000", uart_data); else passes++;
    push = 1'b0; reset = 1'b0;
    @(negedge clk);
    checks++; if (count !== 5'd0 || empty !== 1'b1) $display("FAIL rst_push_ignored got count=%0d want 0", count); else passes++;
  endtask

  task automatic test_latency();
    bit ok;
    do_push(16'hA55A, 1'b1);
    @(negedge clk);
    push = 1'b0;
    checks++; if (count !== 5'd1 || uart_in_and_send !== 1'b0) $display("FAIL lat_edge1 got count=%0d send=%b want 1 0", count, uart_in_and_send); else passes++;
    @(negedge clk);
    checks++; if (uart_in_and_send !== 1'b1 || uart_data !== 16'hA55A) $display("FAIL lat_edge2 got send=%b data=%h want 1 a55a", uart_in_and_send, uart_data); else passes++;
    @(negedge clk);
    checks++; if ({uart_in_and_send, data_oe} !== 2'b00 || uart_data !== 16'hA55A || count !== 5'd0)
      $display("FAIL lat_after got send=%b oe=%b data=%h count=%0d want 0 0 a55a 0", uart_in_and_send, data_oe, uart_data, count); else passes++;
    wait_idle(100, ok);
    checks++; if (!ok) $display("FAIL lat_drain got busy=%b want idle", busy); else passes++;
  endtask

  task automatic test_back_to_back();
    int base = sends;
    bit ok;
    do_push(16'h1111, 1'b1);
    do_push(16'h2222, 1'b1);
    do_push(16'h3333, 1'b1);
    @(negedge clk);
    push = 1'b0;
    wait_idle(300, ok);
    checks++; if (!ok || sends - base != 3) $display("FAIL b2b_sends got %0d ok=%b want 3 1", sends - base, ok); else passes++;
  endtask

  task automatic test_overflow();
    int base = sends;
    bit ok;
    @(negedge clk);
    hold_done = 1'b1;
    for (int i = 0; i < 9; i++) do_push(16'hB000 + 16'(i), i < DEPTH);
    @(negedge clk);
    push = 1'b0;
    checks++; if (count !== 5'd8 || full !== 1'b1 || empty !== 1'b0) $display("FAIL ovf_count got count=%0d full=%b want 8 1", count, full); else passes++;
    checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag got %b want 1", overflow); else passes++;
    checks++; if (sends != base) $display("FAIL ovf_held got %0d sends want 0", sends - base); else passes++;
    hold_done = 1'b0;
    wait_idle(400, ok);
    checks++; if (!ok || sends - base != 8 || overflow !== 1'b1) $display("FAIL ovf_drain got %0d ok=%b ovf=%b want 8 1 1", sends - base, ok, overflow); else passes++;
  endtask

  task automatic test_timeout();
    int n = 0;
    bit ok;
    do_reset();
    uart_dead = 1'b1;
    do_push(16'hC001, 1'b1);
    do_push(16'hC002, 1'b1);
    @(negedge clk);
    push = 1'b0;
    checks++; if (timeout_err !== 1'b0) $display("FAIL to_early got %b want 0", timeout_err); else passes++;
    while (timeout_err !== 1'b1 && n < TO + 20) begin
      @(negedge clk);
      n++;
    end
    checks++; if (cyc - send_cyc != TO + 1) $display("FAIL to_latency got %0d want %0d", cyc - send_cyc, TO + 1); else passes++;
    @(negedge clk);
    checks++; if (uart_in_and_send !== 1'b1) $display("FAIL to_next_send got %b want 1", uart_in_and_send); else passes++;
    wait_idle(2 * TO + 20, ok);
    checks++; if (!ok || timeout_err !== 1'b1) $display("FAIL to_sticky got ok=%b err=%b want 1 1", ok, timeout_err); else passes++;
    uart_dead = 1'b0;
  endtask

  task automatic test_reset_flush();
    int base;
    do_reset();
    uart_dead = 1'b1;
    base = sends;
    for (int i = 0; i < 5; i++) do_push(16'hD000 + 16'(i), i == 0);
    @(negedge clk);
    push = 1'b0;
    checks++; if (count !== 5'd4) $display("FAIL flush_pre got count=%0d want 4", count); else passes++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (count !== 5'd0 || {empty, full, busy} !== 3'b100) $display("FAIL flush_state got count=%0d e/f/b=%b want 0 100", count, {empty, full, busy}); else passes++;
    checks++; if (uart_data !== 16'h0) $display("FAIL flush_data got %h want 0000", uart_data); else passes++;
    repeat (TO + 10) @(negedge clk);
    checks++; if (sends - base != 1 || exp_q.size() != 0) $display("FAIL flush_nosend got %0d want 1", sends - base); else passes++;
    uart_dead = 1'b0;
  endtask

  task automatic test_full_pop();
    int base;
    bit ok;
    do_reset();
    base = sends;
    @(negedge clk);
    hold_done = 1'b1;
    for (int i = 0; i < DEPTH; i++) do_push(16'hE000 + 16'(i), 1'b1);
    @(negedge clk);
    push = 1'b0;
    checks++; if (full !== 1'b1 || overflow !== 1'b0 || count !== 5'd8) $display("FAIL fp_full got full=%b ovf=%b count=%0d want 1 0 8", full, overflow, count); else passes++;
    hold_done = 1'b0;
    @(negedge clk);
    push = 1'b1; push_data = 16'hDEAD;
    @(negedge clk);
    push = 1'b0;
    checks++; if (count !== 5'(DEPTH - 1) || overflow !== 1'b1 || full !== 1'b0) $display("FAIL fp_drop got count=%0d ovf=%b full=%b want 7 1 0", count, overflow, full); else passes++;
    wait_idle(400, ok);
    checks++; if (!ok || sends - base != DEPTH) $display("FAIL fp_drain got %0d ok=%b want 8 1", sends - base, ok); else passes++;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_overflow();
    test_timeout();
    test_reset_flush();
    test_full_pop();
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_queue.md
UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 Parameter DEPTH, default 8: FIFO capacity in 16-bit words; power of two, 2..16.
REQ-002 Parameter TIMEOUT, default 4095: maximum clk cycles spent waiting for uart_done before abandoning a word.
REQ-003 clk  input  1  system clock, 12 MHz, undivided.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 push  input  1  control unit enqueues push_data this cycle.
REQ-006 push_data  input  16  word to transmit, high byte first on the serial line.
REQ-007 full  output  1  FIFO holds DEPTH words.
REQ-008 empty  output  1  FIFO holds 0 words.
REQ-009 count  output  5  number of words currently in the FIFO, 0..DEPTH.
REQ-010 busy  output  1  high whenever the state is not IDLE or count is not 0.
REQ-011 overflow  output  1  sticky flag: a push was dropped.
REQ-012 timeout_err  output  1  sticky flag: a word was abandoned after TIMEOUT cycles.
REQ-013 uart_in_and_send  output  1  one-cycle load/send strobe to the UART.
REQ-014 uart_data  output  16  word presented to the UART DATA bus.
REQ-015 data_oe  output  1  top level drives the UART DATA bus with uart_data while this is high.
REQ-016 uart_done  input  1  UART completion flag, high for one or more cycles after the second byte.

Function
REQ-017 A push with full=0 shall write push_data at the tail; count and the flags shall reflect it on the next edge.
REQ-018 A push with full=1 shall be dropped and shall set overflow, even if a pop occurs in the same cycle.
REQ-019 Simultaneous accepted push and pop shall leave count unchanged and preserve FIFO order.
REQ-020 Read and write pointers shall wrap modulo DEPTH; full and empty shall derive from count only.
REQ-021 The controller shall have exactly four states: IDLE, SEND, WAIT_DONE and WAIT_CLEAR.
REQ-022 IDLE: if count>0 and uart_done=0, the next state shall be SEND; otherwise the state shall remain IDLE.
REQ-023 SEND shall last exactly one cycle, with uart_in_and_send=1, data_oe=1, uart_data=head word, and the head popped in that cycle; the next state shall be WAIT_DONE.
REQ-024 Outside SEND, uart_in_and_send and data_oe shall be 0, and uart_data shall hold the last sent word.
REQ-025 WAIT_DONE: on uart_done=1 the next state shall be WAIT_CLEAR.
REQ-026 WAIT_DONE: a 12-bit wait counter shall increment each cycle; on reaching TIMEOUT, timeout_err shall be set, the word shall be discarded, and the next state shall be IDLE.
REQ-027 WAIT_CLEAR: the state shall remain until uart_done=0, then go to IDLE; no new SEND shall issue while uart_done=1.
REQ-028 Latency: a push into an empty idle queue shall produce uart_in_and_send on the second edge after the push edge.
REQ-029 Back-to-back words: the minimum gap shall be one IDLE cycle after uart_done falls.
REQ-030 overflow and timeout_err shall clear only on reset.

Reset
REQ-031 Reset shall set state=IDLE, pointers=0, count=0, empty=1, full=0, busy=0, overflow=0, timeout_err=0, uart_in_and_send=0, data_oe=0, uart_data=0, and wait counter=0.
REQ-032 Reset asserted mid-transfer shall flush all queued words; a push in the reset cycle shall be ignored.

Structure
REQ-033 The shared include uart_defs shall hold CLOCK_DIVIDE, the default TIMEOUT, and this block's state encodings.
REQ-034 Storage and pointers shall be one sub-module, sync_fifo16 (push/pop/count/full/empty); the controller FSM shall be in uart_tx_queue.

Verification
REQ-035 Push 16'hA55A into an empty queue -> uart_in_and_send for 1 cycle with uart_data=16'hA55A, 2 edges after the push; count returns to 0.
REQ-036 Push 3 words while busy, UART model returning uart_done for 2 cycles each -> three SENDs in order, no SEND while uart_done=1.
REQ-037 Push 9 words with the UART held busy and DEPTH=8 -> count=8, full=1, overflow=1, ninth word never sent.
REQ-038 SEND issued, uart_done never asserted -> timeout_err=1 at TIMEOUT+1 cycles after SEND, state IDLE, next word sent.
REQ-039 Reset in WAIT_DONE with 4 words queued -> next cycle count=0, empty=1, busy=0, no further uart_in_and_send.
REQ-040 Push at full coinciding with SEND pop -> word dropped, overflow=1, count=DEPTH-1.
